// File: rtl/cam_frame_gen_if.sv
// Camera-side bus between the synthetic frame source and the capture stage.
// The source owns every signal; the capture stage only observes.
interface cam_frame_gen_if;
  logic       CAM_vsync;
  logic       CAM_href;
  logic [7:0] CAM_px_data;

  modport master (output CAM_vsync, output CAM_href, output CAM_px_data);
  modport slave  (input  CAM_vsync, input  CAM_href, input  CAM_px_data);
endinterface

// File: rtl/cam_frame_gen.sv
// Synthetic OV7670-style RGB444 frame source: vsync / back porch / active lines / front porch,
// producing two bytes per pixel with solid, colour-bar or pixel-index content.
module cam_frame_gen #(
  parameter int W         = 160,
  parameter int H         = 120,
  parameter int HB_CYC    = 16,
  parameter int VS_LINES  = 3,
  parameter int VBP_LINES = 2,
  parameter int VFP_LINES = 2
) (
  input  logic                  CAM_pclk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [1:0]            pattern,
  input  logic [11:0]           solid_rgb,
  cam_frame_gen_if.master       cam,
  output logic                  frame_done,
  output logic [15:0]           frame_cnt,
  output logic [2:0]            dbg_state_o
);

  localparam int LINE_CYC = 2 * W + HB_CYC;
  localparam int VS_CYC   = VS_LINES * LINE_CYC;
  localparam int VBP_CYC  = VBP_LINES * LINE_CYC;
  localparam int VFP_CYC  = VFP_LINES * LINE_CYC;
  localparam int ACT_CYC  = 2 * W;
  localparam int M1       = (VS_CYC > VBP_CYC) ? VS_CYC : VBP_CYC;
  localparam int M2       = (M1 > VFP_CYC) ? M1 : VFP_CYC;
  localparam int M3       = (M2 > ACT_CYC) ? M2 : ACT_CYC;
  localparam int CNT_MAX  = (M3 > HB_CYC) ? M3 : HB_CYC;
  localparam int CNT_W    = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 2;
  localparam int ROW_W    = (H > 1) ? $clog2(H) : 1;
  localparam int BAR_PX   = W / 8;

  localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(VS_CYC - 1);
  localparam logic [CNT_W-1:0] VBP_LAST = CNT_W'(VBP_CYC - 1);
  localparam logic [CNT_W-1:0] VFP_LAST = CNT_W'(VFP_CYC - 1);
  localparam logic [CNT_W-1:0] ACT_LAST = CNT_W'(ACT_CYC - 1);
  localparam logic [CNT_W-1:0] HB_LAST  = CNT_W'(HB_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(H - 1);
  localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_VSYNC  = 3'd1,
    S_VBP    = 3'd2,
    S_ACTIVE = 3'd3,
    S_HBLANK = 3'd4,
    S_VFP    = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [11:0]      pidx_q, pidx_d;
  logic [1:0]       pat_q, pat_d;
  logic [11:0]      rgb_q, rgb_d;
  logic             done_d;

  logic             vsync_q, href_q, done_q;
  logic [7:0]       px_q, px_d;
  logic [15:0]      fcnt_q;

  logic [CNT_W-2:0] x_nx;
  logic [2:0]       bar;
  logic [11:0]      bar_rgb;
  logic [3:0]       hi_nib;
  logic [7:0]       lo_byte;

  // cnt counts cycles within the current state; in ACTIVE it is the byte index b.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    pidx_d  = pidx_q;
    pat_d   = pat_q;
    rgb_d   = rgb_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d = S_VSYNC;
          cnt_d   = '0;
          pat_d   = pattern;
          rgb_d   = solid_rgb;
        end
      end
      S_VSYNC: begin
        if (cnt_q == VS_LAST) begin
          state_d = S_VBP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_VBP: begin
        if (cnt_q == VBP_LAST) begin
          state_d = S_ACTIVE;
          cnt_d   = '0;
          row_d   = '0;
          pidx_d  = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_ACTIVE: begin
        // The pixel index advances once the second byte of a pixel has gone out.
        if (cnt_q[0]) pidx_d = pidx_q + 12'd1;
        if (cnt_q == ACT_LAST) begin
          state_d = S_HBLANK;
          cnt_d   = '0;
          done_d  = (row_q == ROW_LAST);
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_HBLANK: begin
        if (cnt_q == HB_LAST) begin
          cnt_d = '0;
          if (row_q != ROW_LAST) begin
            state_d = S_ACTIVE;
            row_d   = row_q + ROW_ONE;
          end else begin
            state_d = S_VFP;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_VFP: begin
        if (cnt_q == VFP_LAST) begin
          cnt_d = '0;
          if (enable) begin
            state_d = S_VSYNC;
            pat_d   = pattern;
            rgb_d   = solid_rgb;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are built from next-state values so the registered byte lines up with href.
  always_comb begin
    x_nx = cnt_d[CNT_W-1:1];
    bar  = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (int'(x_nx) >= k * BAR_PX) bar = bar + 3'd1;
    end
    case (bar)
      3'd0:    bar_rgb = 12'hFFF;
      3'd1:    bar_rgb = 12'hFF0;
      3'd2:    bar_rgb = 12'h0FF;
      3'd3:    bar_rgb = 12'h0F0;
      3'd4:    bar_rgb = 12'hF0F;
      3'd5:    bar_rgb = 12'hF00;
      3'd6:    bar_rgb = 12'h00F;
      default: bar_rgb = 12'h000;
    endcase
    case (pat_d)
      2'd1: begin
        hi_nib  = bar_rgb[11:8];
        lo_byte = bar_rgb[7:0];
      end
      2'd2: begin
        hi_nib  = pidx_d[11:8];
        lo_byte = pidx_d[7:0];
      end
      default: begin
        hi_nib  = rgb_d[11:8];
        lo_byte = rgb_d[7:0];
      end
    endcase
    px_d = 8'h00;
    if (state_d == S_ACTIVE) px_d = cnt_d[0] ? lo_byte : {4'h0, hi_nib};
  end

  always_ff @(posedge CAM_pclk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      row_q   <= '0;
      pidx_q  <= '0;
      pat_q   <= '0;
      rgb_q   <= '0;
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      px_q    <= 8'h00;
      done_q  <= 1'b0;
      fcnt_q  <= 16'h0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      pidx_q  <= pidx_d;
      pat_q   <= pat_d;
      rgb_q   <= rgb_d;
      vsync_q <= (state_d == S_VSYNC);
      href_q  <= (state_d == S_ACTIVE);
      px_q    <= px_d;
      done_q  <= done_d;
      if (done_d) fcnt_q <= fcnt_q + 16'd1;
    end
  end

  assign cam.CAM_vsync   = vsync_q;
  assign cam.CAM_href    = href_q;
  assign cam.CAM_px_data = px_q;
  assign frame_done      = done_q;
  assign frame_cnt       = fcnt_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_cam_frame_gen.sv
// Cycle-accurate check of cam_frame_gen against a frame-timeline model: each cycle's
// expected outputs are derived from the position within the frame.
module tb_cam_frame_gen;

  localparam int W         = 32;
  localparam int H         = 130;
  localparam int HB_CYC    = 4;
  localparam int VS_LINES  = 2;
  localparam int VBP_LINES = 1;
  localparam int VFP_LINES = 1;
  localparam int LC        = 2 * W + HB_CYC;
  localparam int FRAME     = (VS_LINES + VBP_LINES + H + VFP_LINES) * LC;
  localparam int ACT_T0    = (VS_LINES + VBP_LINES) * LC;
  localparam int DONE_T    = ACT_T0 + (H - 1) * LC + 2 * W;
  localparam int VW        = 27;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [1:0]  pattern;
  logic [11:0] solid_rgb;
  logic        frame_done;
  logic [15:0] frame_cnt;
  logic [2:0]  dbg_state;

  cam_frame_gen_if cam_if ();

  cam_frame_gen #(
    .W(W), .H(H), .HB_CYC(HB_CYC),
    .VS_LINES(VS_LINES), .VBP_LINES(VBP_LINES), .VFP_LINES(VFP_LINES)
  ) dut (
    .CAM_pclk   (clk),
    .rst        (rst),
    .enable     (enable),
    .pattern    (pattern),
    .solid_rgb  (solid_rgb),
    .cam        (cam_if.master),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt),
    .dbg_state_o(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // Reference model: t is the cycle position inside the running frame, -1 when idle.
  int          m_t    = -1;
  logic [1:0]  m_pat  = 2'd0;
  logic [11:0] m_rgb  = 12'h000;
  logic [15:0] m_fcnt = 16'h0000;
  logic [11:0] bar_col [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                               12'hF0F, 12'hF00, 12'h00F, 12'h000};
  logic [VW-1:0] exp_q[$];

  function automatic logic [10:0] frame_outputs(input int t, input logic [1:0] pat,
                                                input logic [11:0] rgb);
    int          u, row, b, x, p;
    logic [11:0] c;
    logic [11:0] pv;
    logic [7:0]  byt;
    if (t < 0) return 11'd0;
    if (t < VS_LINES * LC) return {1'b1, 1'b0, 8'h00, 1'b0};
    u = t - ACT_T0;
    if (u < 0 || u >= H * LC) return 11'd0;
    row = u / LC;
    b   = u % LC;
    if (b >= 2 * W) return {2'b00, 8'h00, (t == DONE_T)};
    x = b / 2;
    case (pat)
      2'd1:    c = bar_col[x / (W / 8)];
      2'd2: begin
        p  = (row * W + x) % 4096;
        pv = p[11:0];
        c  = pv;
      end
      default: c = rgb;
    endcase
    byt = (b % 2 == 1) ? c[7:0] : {4'h0, c[11:8]};
    return {1'b0, 1'b1, byt, 1'b0};
  endfunction

  // Scoreboard: advance the model on each edge, compare just after it.
  always @(posedge clk) begin
    logic [VW-1:0] exp_v, got_v;
    if (rst) begin
      m_t    = -1;
      m_fcnt = 16'h0000;
    end else if (m_t < 0) begin
      if (enable) begin
        m_t   = 0;
        m_pat = pattern;
        m_rgb = solid_rgb;
      end
    end else begin
      m_t = m_t + 1;
      if (m_t == FRAME) begin
        if (enable) begin
          m_t   = 0;
          m_pat = pattern;
          m_rgb = solid_rgb;
        end else begin
          m_t = -1;
        end
      end
      if (m_t == DONE_T) m_fcnt = m_fcnt + 16'd1;
    end
    exp_q.push_back({frame_outputs(m_t, m_pat, m_rgb), m_fcnt});
    #1;
    got_v = {cam_if.CAM_vsync, cam_if.CAM_href, cam_if.CAM_px_data, frame_done, frame_cnt};
    exp_v = exp_q.pop_front();
    check_eq("outs{vs,href,px,done,fcnt}", 32'(got_v), 32'(exp_v));
  end

  // Driver tasks
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_frame(input logic [1:0] pat, input logic [11:0] rgb);
    pattern   = pat;
    solid_rgb = rgb;
  endtask

  initial begin
    rst       = 1'b1;
    enable    = 1'b0;
    pattern   = 2'd0;
    solid_rgb = 12'h000;
    cycles(3);
    rst = 1'b0;
    cycles(1000);

    // Solid, then colour bars, then pixel index; pattern changes mid-frame must wait for the next frame.
    set_frame(2'd0, 12'hA5C);
    enable = 1'b1;
    cycles(FRAME / 2);
    set_frame(2'd1, 12'($urandom_range(0, 4095)));
    cycles(FRAME - FRAME / 2);
    cycles(FRAME / 2);
    set_frame(2'd2, 12'($urandom_range(0, 4095)));
    cycles(FRAME - FRAME / 2);
    cycles(FRAME / 2);
    set_frame(2'($urandom_range(0, 3)), 12'($urandom_range(0, 4095)));
    cycles(FRAME - FRAME / 2);

    // Drop enable at row 60: the frame must still finish, then stay idle.
    cycles(ACT_T0 + 60 * LC + int'($urandom_range(0, 2 * W)));
    enable = 1'b0;
    cycles(FRAME + 300);

    // Reset in the middle of row 50.
    set_frame(2'($urandom_range(0, 3)), 12'($urandom_range(0, 4095)));
    enable = 1'b1;
    cycles(ACT_T0 + 50 * LC + 7);
    rst    = 1'b1;
    enable = 1'b0;
    cycles(2);
    rst = 1'b0;
    cycles(20);

    // Re-enable for exactly one full frame.
    set_frame(2'($urandom_range(0, 3)), 12'($urandom_range(0, 4095)));
    enable = 1'b1;
    cycles(10);
    enable = 1'b0;
    cycles(FRAME + 50);

    check_eq("final_frame_cnt", 32'(frame_cnt), 32'(m_fcnt));
    check_eq("final_vsync_low", 32'(cam_if.CAM_vsync), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
